instr_mem_responder: RTL
========================

// Module: instr_mem_responder
// PURPOSE
//   Instruction-memory responder: answers fetch requests from the program counter.
//   Each request presents a byte address. The block returns the addressed 32-bit
//   word after a programmable number of wait states, using a valid/ack handshake.
//   It holds a word-addressed instruction array with a write-only load port for
//   the bench and boot loader. It flags misaligned and out-of-range fetches.
// PARAMETERS
//   DEPTH_WORDS  256  instruction words stored; power of two, >= 4
//   WAIT_STATES  2    extra cycles between request accept and instr_valid; 0..15
// PORTS
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous, active-low reset
//   fetch_req      in   1   fetch request; qualified by fetch_ready
//   fetch_addr     in   32  byte address of the instruction
//   fetch_ready    out  1   responder can accept a request this cycle
//   instr_out      out  32  fetched instruction word
//   instr_valid    out  1   instr_out/fault flags valid; held until instr_ack
//   instr_ack      in   1   consumer takes the response
//   misalign_fault out  1   with instr_valid: fetch_addr[1:0] != 0
//   range_fault    out  1   with instr_valid: fetch_addr[31:2] >= DEPTH_WORDS
//   load_en        in   1   write instruction word this cycle
//   load_addr      in   32  byte address for load; bits [1:0] ignored
//   load_data      in   32  word written
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, wait counter=0, instr_out=0, instr_valid=0,
//   both faults=0. Array contents are not cleared. A response in flight is discarded.
// - FSM:
//   - IDLE: fetch_ready=1. On fetch_req, latch fetch_addr.
//     - If WAIT_STATES>0, go to WAIT with counter=WAIT_STATES-1.
//     - Otherwise go to RESP.
//   - WAIT: decrement the counter each cycle. When the counter reaches 0, go to RESP next edge.
//   - RESP: instr_valid=1. Outputs are stable until acked.
//     - On instr_ack with no fetch_req, go to IDLE.
//     - On instr_ack with fetch_req in the same cycle, accept the new request (back-to-back)
//       and go to WAIT or RESP, as from IDLE.
// - Latency: instr_valid rises exactly WAIT_STATES+1 edges after the accepting edge.
// - fetch_ready = (state==IDLE) | (state==RESP & instr_ack). Combinational from state/ack.
// - A fetch_req seen while fetch_ready=0 is ignored, not queued.
// - Response data:
//   - Sampled from the array on the edge that enters RESP.
//   - Word index = latched addr[log2(DEPTH_WORDS)+1:2].
//   - A load to that index on or before the sampling edge is visible (write-first).
// - Faults:
//   - Misaligned or out-of-range: instr_out=32'h0000_0000 (NOP) and the matching fault=1.
//     Both faults may be set together.
//   - Faults are 0 whenever instr_valid=0.
// - Load port:
//   - load_en writes array[load_addr[log2(DEPTH_WORDS)+1:2]] on the rising edge, in any state.
//   - An out-of-range load (load_addr[31:2] >= DEPTH_WORDS) is dropped.
//   - Load never stalls a fetch.
// - instr_ack while instr_valid=0 is ignored.
// TESTING
// 1. Reset mid-WAIT (WAIT_STATES=2): drop reset during WAIT -> instr_valid=0 at once,
//    fetch_ready=1; no response ever appears.
// 2. Load 0x20080005 at addr 0x0, fetch 0x0 (WAIT_STATES=2) -> instr_valid rises 3 edges
//    after accept; instr_out=0x20080005; faults=0; held until ack.
// 3. Back-to-back: ack + fetch_req(0x4) in the same RESP cycle -> new request accepted;
//    next instr_valid 3 edges later with array[1].
// 4. fetch 0x6 -> misalign_fault=1, instr_out=0. fetch 0x400 (DEPTH=256) -> range_fault=1,
//    instr_out=0.
// 5. During WAIT for 0x8, load 0xDEADBEEF at 0x8 -> response instr_out=0xDEADBEEF.
//    Load at 0x400 -> array unchanged.
// 6. WAIT_STATES=0: fetch 0xC -> instr_valid on the first edge after accept; consumer holds
//    ack low 5 cycles -> outputs stable, fetch_ready=0.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: byte-addressed fetches answered after WAIT_STATES
// wait cycles over a valid/ack handshake, with a write-only word load port.
module instr_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ack,
    output logic        misalign_fault,
    output logic        range_fault,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    // state  | meaning
    // S_IDLE | no request outstanding, ready for a fetch
    // S_WAIT | request latched, counting down wait states
    // S_RESP | response held on instr_out until instr_ack
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic        enter_resp;
    logic        accept;
    logic        mis_q, rng_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          load_ok;
    logic [AW-1:0] load_idx;
    logic [31:0]   samp_addr;
    logic [AW-1:0] samp_idx;
    logic          samp_mis, samp_rng;
    logic [31:0]   samp_word;
    logic          unused_load_lsbs;

    assign unused_load_lsbs = ^load_addr[1:0];

    assign fetch_ready = (state == S_IDLE) || ((state == S_RESP) && instr_ack);
    assign accept      = fetch_req && fetch_ready;

    assign load_idx = load_addr[AW+1:2];
    assign load_ok  = load_en && (load_addr[31:2] < 30'(DEPTH_WORDS));

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        addr_nxt   = addr_q;
        enter_resp = 1'b0;
        case (state)
            S_IDLE, S_RESP: begin
                if ((state == S_RESP) && instr_ack) state_nxt = S_IDLE;
                if (accept) begin
                    addr_nxt = fetch_addr;
                    if (WAIT_STATES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_nxt  = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt  = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the sampling edge is the accepting edge, so the
    // address comes straight from the port rather than the latch.
    assign samp_addr = (state == S_WAIT) ? addr_q : fetch_addr;
    assign samp_idx  = samp_addr[AW+1:2];
    assign samp_mis  = |samp_addr[1:0];
    assign samp_rng  = samp_addr[31:2] >= 30'(DEPTH_WORDS);
    assign samp_word = (load_ok && (load_idx == samp_idx)) ? load_data : mem[samp_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            addr_q    <= 32'd0;
            instr_out <= 32'd0;
            mis_q     <= 1'b0;
            rng_q     <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            addr_q <= addr_nxt;
            if (enter_resp) begin
                instr_out <= (samp_mis || samp_rng) ? 32'h0000_0000 : samp_word;
                mis_q     <= samp_mis;
                rng_q     <= samp_rng;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_ok) mem[load_idx] <= load_data;
    end

    assign instr_valid    = (state == S_RESP);
    assign misalign_fault = mis_q && instr_valid;
    assign range_fault    = rng_q && instr_valid;

endmodule
